// File: rtl/csr_unit_pkg.sv
// Shared definitions for the machine-mode CSR file:
// addresses, op encodings, bit positions and the write-value helper.
package csr_unit_pkg;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    localparam logic [11:0] CSR_HPMEVT_BASE   = 12'h320;
    localparam logic [11:0] CSR_HPMCNT_BASE   = 12'hB00;
    localparam logic [11:0] CSR_HPMCNTH_BASE  = 12'hB80;

    // addr[11:5] pages holding the 3..31 HPM index ranges
    localparam logic [6:0] HPMEVT_PAGE  = 7'h19;
    localparam logic [6:0] HPMCNT_PAGE  = 7'h58;
    localparam logic [6:0] HPMCNTH_PAGE = 7'h5C;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SET   = 2'b10,
        OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        MTVEC_DIRECT   = 2'b00,
        MTVEC_VECTORED = 2'b01
    } mtvec_mode_e;

    localparam int MST_MIE    = 3;
    localparam int MST_MPIE   = 7;
    localparam int MST_MPP_LO = 11;
    localparam int MST_MPP_HI = 12;

    localparam int IRQ_MSI_BIT = 3;
    localparam int IRQ_MTI_BIT = 7;
    localparam int IRQ_MEI_BIT = 11;

    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    function automatic logic [31:0] csr_wval(
        input csr_op_e     op,
        input logic [31:0] old,
        input logic [31:0] wd
    );
        logic [31:0] r;
        r = old;
        unique case (op)
            OP_WRITE: r = wd;
            OP_SET:   r = old | wd;
            OP_CLEAR: r = old & ~wd;
            default:  r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/csr_unit_counter64.sv
// 64-bit event counter with inhibit and independent
// half-word write strobes; a write wins over the increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inhibit,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (wr_lo) begin
            cnt[31:0] <= wdata;
        end else if (wr_hi) begin
            cnt[63:32] <= wdata;
        end else if (inc && !inhibit) begin
            cnt <= cnt + 64'd1;
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: combinational read, trap/mret/write
// commit on posedge clk, counters and interrupt arbitration.
module csr_unit
    import csr_unit_pkg::*;
#(
    parameter int          NUM_HPM   = 4,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] VENDOR_ID = 32'h0973_7978,
    parameter logic [31:0] ARCH_ID   = 32'h016f_959d,
    parameter logic [31:0] HART_ID   = 32'd0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_csr_ren,
    input  logic               ex_csr_wen,
    input  logic [1:0]         ex_csr_op,
    input  logic [11:0]        ex_csr_addr,
    input  logic [31:0]        ex_csr_wdata,
    input  logic               ex_trap_valid,
    input  logic [31:0]        ex_trap_pc,
    input  logic [31:0]        ex_trap_cause,
    input  logic [31:0]        ex_trap_tval,
    input  logic               ex_irq_take,
    input  logic               ex_mret,
    input  logic               ex_retire,
    input  logic [NUM_HPM-1:0] hpm_event,
    input  logic               irq_ext,
    input  logic               irq_timer,
    input  logic               irq_soft,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    output logic               csr_irq_pending,
    output logic [31:0]        csr_irq_cause,
    output logic [31:0]        csr_trap_vector,
    output logic [31:0]        csr_mepc
);

    localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam logic [31:0] INH_MASK =
        32'h5 | (32'((64'h1 << NUM_HPM) - 64'h1) << 3);

    logic        mst_mie;
    logic        mst_mpie;
    logic [1:0]  mst_mpp;
    logic [31:0] mie_r;
    logic [31:0] mip_r;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [29:0] mtvec_base;
    mtvec_mode_e mtvec_mode;
    logic [31:0] minh;
    logic [31:0] hpm_evt [HPM_W];

    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] hpm_cnt [HPM_W];

    csr_op_e     op_e;
    logic [31:0] rval;
    logic [31:0] wv;
    logic        impl;
    logic        hpm_in;
    logic [31:0] hpm_lo_sel;
    logic [31:0] hpm_hi_sel;
    logic [31:0] hpm_evt_sel;
    logic        trap_en;
    logic        csr_we;
    logic [31:0] irq_act;
    logic [4:0]  irq_code;
    logic [31:0] vec_base;
    logic        irq_path;

    assign op_e    = csr_op_e'(ex_csr_op);
    assign hpm_in  = ex_csr_addr[4:0] >= 5'd3;
    assign trap_en = ex_trap_valid | ex_irq_take;

    always_comb begin
        hpm_lo_sel  = '0;
        hpm_hi_sel  = '0;
        hpm_evt_sel = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (ex_csr_addr[4:0] == 5'(i + 3)) begin
                hpm_lo_sel  = hpm_cnt[i][31:0];
                hpm_hi_sel  = hpm_cnt[i][63:32];
                hpm_evt_sel = hpm_evt[i];
            end
        end
    end

    always_comb begin
        impl = 1'b1;
        rval = '0;
        unique case (ex_csr_addr)
            CSR_MSTATUS: begin
                rval[MST_MIE]                = mst_mie;
                rval[MST_MPIE]               = mst_mpie;
                rval[MST_MPP_HI:MST_MPP_LO]  = mst_mpp;
            end
            CSR_MIE:           rval = mie_r;
            CSR_MTVEC:         rval = {mtvec_base, mtvec_mode};
            CSR_MCOUNTINHIBIT: rval = minh;
            CSR_MSCRATCH:      rval = mscratch;
            CSR_MEPC:          rval = mepc;
            CSR_MCAUSE:        rval = mcause;
            CSR_MTVAL:         rval = mtval;
            CSR_MIP:           rval = mip_r;
            CSR_MCYCLE,
            CSR_CYCLE:         rval = mcycle[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:        rval = mcycle[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:       rval = minstret[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH:      rval = minstret[63:32];
            CSR_MVENDORID:     rval = VENDOR_ID;
            CSR_MARCHID:       rval = ARCH_ID;
            CSR_MIMPID:        rval = '0;
            CSR_MHARTID:       rval = HART_ID;
            default: begin
                // Unpopulated HPM slots decode as legal and read 0
                if (hpm_in && ex_csr_addr[11:5] == HPMEVT_PAGE) begin
                    rval = hpm_evt_sel;
                end else if (hpm_in && ex_csr_addr[11:5] == HPMCNT_PAGE) begin
                    rval = hpm_lo_sel;
                end else if (hpm_in && ex_csr_addr[11:5] == HPMCNTH_PAGE) begin
                    rval = hpm_hi_sel;
                end else begin
                    impl = 1'b0;
                end
            end
        endcase
    end

    assign csr_illegal = (ex_csr_ren | ex_csr_wen) &
                         (!impl |
                          (ex_csr_wen & (ex_csr_addr[11:10] == 2'b11)) |
                          (ex_csr_wen & (op_e == OP_NONE)));

    assign csr_rdata = ex_csr_ren ? rval : 32'd0;
    assign wv        = csr_wval(op_e, rval, ex_csr_wdata);
    assign csr_we    = ex_csr_wen & !csr_illegal & !trap_en & !ex_mret;
    assign csr_mepc  = mepc;

    assign irq_act         = mip_r & mie_r;
    assign csr_irq_pending = mst_mie & (|irq_act);

    always_comb begin
        irq_code = '0;
        if (irq_act[IRQ_MEI_BIT]) begin
            irq_code = IRQ_CODE_MEI;
        end else if (irq_act[IRQ_MSI_BIT]) begin
            irq_code = IRQ_CODE_MSI;
        end else if (irq_act[IRQ_MTI_BIT]) begin
            irq_code = IRQ_CODE_MTI;
        end
    end

    assign csr_irq_cause = (|irq_act) ? {1'b1, 26'b0, irq_code} : 32'd0;

    assign irq_path = ex_irq_take & !ex_trap_valid;
    assign vec_base = {mtvec_base, 2'b00};

    always_comb begin
        csr_trap_vector = vec_base;
        if (irq_path && mtvec_mode == MTVEC_VECTORED) begin
            csr_trap_vector = vec_base + {25'b0, irq_code, 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mip_r <= '0;
        end else begin
            mip_r <= {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mst_mpp    <= PRIV_M;
            mie_r      <= '0;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mtvec_base <= MTVEC_RST[31:2];
            mtvec_mode <= mtvec_mode_e'(MTVEC_RST[1:0]);
            minh       <= '0;
            for (int i = 0; i < HPM_W; i++) begin
                hpm_evt[i] <= '0;
            end
        end else if (trap_en) begin
            mepc     <= {ex_trap_pc[31:2], 2'b00};
            mst_mpie <= mst_mie;
            mst_mie  <= 1'b0;
            mst_mpp  <= PRIV_M;
            if (ex_trap_valid) begin
                mcause <= ex_trap_cause;
                mtval  <= ex_trap_tval;
            end else begin
                mcause <= csr_irq_cause;
                mtval  <= '0;
            end
        end else if (ex_mret) begin
            mst_mie  <= mst_mpie;
            mst_mpie <= 1'b1;
            mst_mpp  <= PRIV_U;
        end else if (csr_we) begin
            unique case (ex_csr_addr)
                CSR_MSTATUS: begin
                    mst_mie  <= wv[MST_MIE];
                    mst_mpie <= wv[MST_MPIE];
                    if (wv[MST_MPP_HI:MST_MPP_LO] == PRIV_M ||
                        wv[MST_MPP_HI:MST_MPP_LO] == PRIV_U) begin
                        mst_mpp <= wv[MST_MPP_HI:MST_MPP_LO];
                    end
                end
                CSR_MIE: mie_r <= wv & MIE_MASK;
                CSR_MTVEC: begin
                    mtvec_base <= wv[31:2];
                    if (!wv[1]) begin
                        mtvec_mode <= mtvec_mode_e'(wv[1:0]);
                    end
                end
                CSR_MCOUNTINHIBIT: minh     <= wv & INH_MASK;
                CSR_MSCRATCH:      mscratch <= wv;
                CSR_MEPC:          mepc     <= {wv[31:2], 2'b00};
                CSR_MCAUSE:        mcause   <= wv;
                CSR_MTVAL:         mtval    <= wv;
                default: begin
                    for (int i = 0; i < NUM_HPM; i++) begin
                        if (ex_csr_addr == CSR_HPMEVT_BASE + 12'(i + 3)) begin
                            hpm_evt[i] <= wv;
                        end
                    end
                end
            endcase
        end
    end

    csr_counter64 u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inhibit (minh[0]),
        .inc     (1'b1),
        .wr_lo   (csr_we && ex_csr_addr == CSR_MCYCLE),
        .wr_hi   (csr_we && ex_csr_addr == CSR_MCYCLEH),
        .wdata   (wv),
        .cnt     (mcycle)
    );

    csr_counter64 u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inhibit (minh[2]),
        .inc     (ex_retire),
        .wr_lo   (csr_we && ex_csr_addr == CSR_MINSTRET),
        .wr_hi   (csr_we && ex_csr_addr == CSR_MINSTRETH),
        .wdata   (wv),
        .cnt     (minstret)
    );

    for (genvar i = 0; i < HPM_W; i++) begin : g_hpm
        if (i < NUM_HPM) begin : g_on
            csr_counter64 u_hpm (
                .clk     (clk),
                .rst     (rst),
                .inhibit (minh[i + 3]),
                .inc     (hpm_event[i] && (|hpm_evt[i])),
                .wr_lo   (csr_we &&
                          ex_csr_addr == CSR_HPMCNT_BASE + 12'(i + 3)),
                .wr_hi   (csr_we &&
                          ex_csr_addr == CSR_HPMCNTH_BASE + 12'(i + 3)),
                .wdata   (wv),
                .cnt     (hpm_cnt[i])
            );
        end else begin : g_off
            assign hpm_cnt[i] = '0;
        end
    end

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: table of register accesses
// plus hand sequences for counters, interrupts, traps and reset.
module tb_csr_unit;

    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
    localparam logic [31:0] VENDOR    = 32'h0973_7978;
    localparam logic [31:0] ARCH      = 32'h016f_959d;
    localparam logic [31:0] HART      = 32'd5;

    logic        clk;
    logic        rst;
    logic        ren;
    logic        wen;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        trap;
    logic [31:0] tpc;
    logic [31:0] tcause;
    logic [31:0] tval;
    logic        take;
    logic        mret;
    logic        retire;
    logic [1:0]  hpm;
    logic        iext;
    logic        itim;
    logic        isoft;
    logic [31:0] rdata;
    logic        ill;
    logic        pend;
    logic [31:0] cause;
    logic [31:0] vec;
    logic [31:0] mepc;

    int tests = 0;
    int fails = 0;

    csr_unit #(
        .NUM_HPM   (2),
        .MTVEC_RST (MTVEC_RST),
        .VENDOR_ID (VENDOR),
        .ARCH_ID   (ARCH),
        .HART_ID   (HART)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_csr_ren      (ren),
        .ex_csr_wen      (wen),
        .ex_csr_op       (op),
        .ex_csr_addr     (addr),
        .ex_csr_wdata    (wdata),
        .ex_trap_valid   (trap),
        .ex_trap_pc      (tpc),
        .ex_trap_cause   (tcause),
        .ex_trap_tval    (tval),
        .ex_irq_take     (take),
        .ex_mret         (mret),
        .ex_retire       (retire),
        .hpm_event       (hpm),
        .irq_ext         (iext),
        .irq_timer       (itim),
        .irq_soft        (isoft),
        .csr_rdata       (rdata),
        .csr_illegal     (ill),
        .csr_irq_pending (pend),
        .csr_irq_cause   (cause),
        .csr_trap_vector (vec),
        .csr_mepc        (mepc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string       nm;
        logic        ren;
        logic        wen;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_ill;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(string n, logic r, logic w, logic [1:0] o,
                                logic [11:0] a, logic [31:0] d,
                                logic [31:0] e, logic i);
        vec_t v;
        v.nm = n; v.ren = r; v.wen = w; v.op = o;
        v.addr = a; v.wdata = d; v.exp_rd = e; v.exp_ill = i;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        ren = 0; wen = 0; op = 0; addr = 0; wdata = 0;
        trap = 0; take = 0; mret = 0; retire = 0; hpm = 0;
    endtask

    task automatic peek(input logic [11:0] a, input logic [31:0] e,
                        input string nm);
        ren = 1; addr = a;
        #1;
        chk(nm, rdata, e);
    endtask

    task automatic wr(input logic [1:0] o, input logic [11:0] a,
                      input logic [31:0] d);
        step();
        wen = 1; op = o; addr = a; wdata = d;
    endtask

    initial begin
        tbl[0]  = mk("mstatus_rst", 1, 0, 0, 12'h300, 0, 32'h1800, 0);
        tbl[1]  = mk("mtvec_rst",   1, 0, 0, 12'h305, 0, MTVEC_RST, 0);
        tbl[2]  = mk("mhartid",     1, 0, 0, 12'hF14, 0, HART, 0);
        tbl[3]  = mk("mvendorid",   1, 0, 0, 12'hF11, 0, VENDOR, 0);
        tbl[4]  = mk("marchid",     1, 0, 0, 12'hF12, 0, ARCH, 0);
        tbl[5]  = mk("mip_rst",     1, 0, 0, 12'h344, 0, 0, 0);
        tbl[6]  = mk("mscr_wr",  1, 1, 1, 12'h340, 32'hA5A5_0000, 0, 0);
        tbl[7]  = mk("mscr_set", 1, 1, 2, 12'h340, 32'h0000_00FF,
                     32'hA5A5_0000, 0);
        tbl[8]  = mk("mscr_clr", 1, 1, 3, 12'h340, 32'hA500_0000,
                     32'hA5A5_00FF, 0);
        tbl[9]  = mk("mscr_rd",  1, 0, 0, 12'h340, 0, 32'h00A5_00FF, 0);
        tbl[10] = mk("mepc_wr",  0, 1, 1, 12'h341, 32'h1237, 0, 0);
        tbl[11] = mk("mepc_rd",  1, 0, 0, 12'h341, 0, 32'h1234, 0);
        tbl[12] = mk("mtvec_wr", 0, 1, 1, 12'h305, 32'h1003, 0, 0);
        tbl[13] = mk("mtvec_rd", 1, 0, 0, 12'h305, 0, 32'h1000, 0);
        tbl[14] = mk("mpp10_wr", 1, 1, 1, 12'h300, 32'h1000, 32'h1800, 0);
        tbl[15] = mk("mpp10_rd", 1, 0, 0, 12'h300, 0, 32'h1800, 0);
        tbl[16] = mk("mpp00_wr", 0, 1, 1, 12'h300, 0, 0, 0);
        tbl[17] = mk("mpp00_rd", 1, 0, 0, 12'h300, 0, 0, 0);
        tbl[18] = mk("ro_wr",    1, 1, 1, 12'hF14, 1, HART, 1);
        tbl[19] = mk("unimpl",   1, 0, 0, 12'h7C0, 0, 0, 1);
        tbl[20] = mk("op_none",  0, 1, 0, 12'h340, 32'hFFFF, 0, 1);
        tbl[21] = mk("mscr_hold",1, 0, 0, 12'h340, 0, 32'h00A5_00FF, 0);
        tbl[22] = mk("ren_off",  0, 0, 0, 12'h340, 0, 0, 0);
        tbl[23] = mk("mie_wr",   1, 1, 1, 12'h304, 32'hFFFF_FFFF, 0, 0);
        tbl[24] = mk("mie_rd",   1, 0, 0, 12'h304, 0, 32'h888, 0);
        tbl[25] = mk("mie_clr",  0, 1, 1, 12'h304, 0, 0, 0);
        tbl[26] = mk("minh_rd",  1, 0, 0, 12'h320, 0, 0, 0);
        tbl[27] = mk("misa_ill", 1, 0, 0, 12'h301, 0, 0, 1);

        rst = 1; ren = 0; wen = 0; op = 0; addr = 0; wdata = 0;
        trap = 0; tpc = 0; tcause = 0; tval = 0; take = 0; mret = 0;
        retire = 0; hpm = 0; iext = 0; itim = 0; isoft = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_pending", {31'b0, pend}, 0);
        chk("rst_illegal", {31'b0, ill}, 0);
        chk("rst_rdata", rdata, 0);

        for (int i = 0; i < 28; i++) begin
            step();
            ren = tbl[i].ren; wen = tbl[i].wen; op = tbl[i].op;
            addr = tbl[i].addr; wdata = tbl[i].wdata;
            #1;
            chk({tbl[i].nm, "_rd"}, rdata, tbl[i].exp_rd);
            chk({tbl[i].nm, "_ill"}, {31'b0, ill}, {31'b0, tbl[i].exp_ill});
        end

        // mcycle half writes, carry into the high half, read-only alias
        wr(1, 12'hB00, 32'hFFFF_FFFF);
        wr(1, 12'hB80, 32'h0);
        step();
        step();
        step();
        peek(12'hB80, 1, "mcycleh_carry");
        peek(12'hB00, 1, "mcycle_carry");
        peek(12'hC00, 1, "cycle_alias");
        wen = 1; op = 1; addr = 12'hC00; wdata = 32'h55;
        #1;
        chk("cycle_ro_ill", {31'b0, ill}, 1);
        step();
        peek(12'hB00, 2, "cycle_ro_nochg");

        // 64-bit wrap
        wr(1, 12'hB80, 32'hFFFF_FFFF);
        wr(1, 12'hB00, 32'hFFFF_FFFE);
        step();
        peek(12'hB00, 32'hFFFF_FFFE, "wrap_lo0");
        peek(12'hB80, 32'hFFFF_FFFF, "wrap_hi0");
        step();
        peek(12'hB00, 32'hFFFF_FFFF, "wrap_lo1");
        step();
        peek(12'hB00, 0, "wrap_lo2");
        peek(12'hB80, 0, "wrap_hi2");

        // mcycle inhibit
        wr(2, 12'h320, 1);
        step();
        peek(12'hB00, 2, "inh_cyc0");
        step();
        peek(12'hB00, 2, "inh_cyc1");
        wr(3, 12'h320, 1);

        // minstret
        for (int i = 0; i < 3; i++) begin
            step();
            retire = 1;
        end
        step();
        peek(12'hB02, 3, "minstret");
        peek(12'hC02, 3, "instret_alias");
        peek(12'hB82, 0, "minstreth");

        // external interrupt through vectored mtvec
        wr(1, 12'h305, 32'h8000_0001);
        wr(1, 12'h304, 32'h800);
        wr(1, 12'h300, 32'h8);
        step();
        iext = 1;
        #1;
        chk("irq_latency", {31'b0, pend}, 0);
        step();
        #1;
        chk("irq_pending", {31'b0, pend}, 1);
        chk("irq_cause_mei", cause, 32'h8000_000B);
        take = 1; tpc = 32'h100;
        #1;
        chk("irq_vector", vec, 32'h8000_002C);
        step();
        peek(12'h341, 32'h100, "irq_mepc");
        chk("irq_mepc_port", mepc, 32'h100);
        chk("irq_masked", {31'b0, pend}, 0);
        peek(12'h300, 32'h1880, "irq_mstatus");
        peek(12'h342, 32'h8000_000B, "irq_mcause");
        peek(12'h343, 0, "irq_mtval");

        // MSI beats MTI; mret restores MIE
        step();
        iext = 0; itim = 1; isoft = 1;
        wen = 1; op = 1; addr = 12'h304; wdata = 32'h888;
        step();
        #1;
        chk("irq_cause_msi", cause, 32'h8000_0003);
        chk("msi_masked", {31'b0, pend}, 0);
        mret = 1;
        step();
        peek(12'h300, 32'h88, "mret_mstatus");
        chk("mret_pending", {31'b0, pend}, 1);

        // exception beats interrupt and CSR write in the same cycle
        wr(1, 12'h340, 32'h55);
        step();
        trap = 1; tcause = 2; tval = 32'hDEAD; tpc = 32'h204; take = 1;
        wen = 1; op = 1; addr = 12'h340; wdata = 32'h1234;
        #1;
        chk("exc_vector", vec, 32'h8000_0000);
        step();
        itim = 0; isoft = 0;
        peek(12'h342, 2, "exc_mcause");
        peek(12'h343, 32'hDEAD, "exc_mtval");
        peek(12'h340, 32'h55, "exc_mscr_hold");
        peek(12'h341, 32'h204, "exc_mepc");
        peek(12'h300, 32'h1880, "exc_mstatus");

        // HPM counters
        wr(1, 12'h323, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            hpm = 2'b11;
        end
        step();
        peek(12'hB03, 5, "hpm3_count");
        peek(12'hB04, 0, "hpm4_no_event");
        wen = 1; op = 1; addr = 12'hB05; wdata = 32'h77;
        #1;
        chk("hpm5_wr_ill", {31'b0, ill}, 0);
        chk("hpm5_wr_rd", rdata, 0);
        step();
        peek(12'hB05, 0, "hpm5_ignored");
        chk("hpm5_legal", {31'b0, ill}, 0);
        wr(2, 12'h320, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step();
            hpm = 2'b01;
        end
        step();
        peek(12'hB03, 5, "hpm3_inhibit");
        peek(12'h320, 32'h8, "minh_bit3");

        // reset in the middle of a write
        step();
        rst = 1; iext = 1;
        wen = 1; op = 1; addr = 12'h340; wdata = 32'h99;
        step();
        rst = 0; iext = 0;
        peek(12'h340, 0, "rst_mscratch");
        peek(12'h300, 32'h1800, "rst_mstatus2");
        peek(12'h305, MTVEC_RST, "rst_mtvec2");
        peek(12'hB03, 0, "rst_hpm3");
        chk("rst_pending2", {31'b0, pend}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
